// File: rtl/territory_scorer.sv
// territory_scorer: scores a Go board by flood-filling reachability of empty
// cells from black and white stones, one pass per cycle, then tallies area or
// territory scores, the komi-adjusted margin and the winner.
module territory_scorer #(
   parameter int N  = 9,
   parameter int CW = 10
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [N-1:0][N-1:0][1:0]  board_state,
   input  logic                      update_pulse,
   input  logic                      mode_in,
   input  logic [7:0]                bcapt_in,
   input  logic [7:0]                wcapt_in,
   input  logic [7:0]                komi_in,
   output logic [CW-1:0]             bcount_out,
   output logic [CW-1:0]             wcount_out,
   output logic signed [CW+1:0]      margin_out,
   output logic [1:0]                winner_out,
   output logic                      busy_out,
   output logic                      terr_ready
);

   localparam int CELLS = N * N;
   localparam int PW    = $clog2(CELLS + 1);

   typedef enum logic [4:0] {
      IDLE        = 5'b00001,
      SNAPSHOT    = 5'b00010,
      PROPAGATE   = 5'b00100,
      TALLY       = 5'b01000,
      PULSE_READY = 5'b10000
   } state_t;

   state_t                     state_q, state_d;
   logic                       pending_q, pending_d;
   logic [PW-1:0]              pass_q;
   logic                       last_pass;
   logic                       changed;

   logic [N-1:0][N-1:0][1:0]   board_q;
   logic                       mode_q;
   logic [7:0]                 bcapt_q, wcapt_q, komi_q;

   logic [N-1:0][N-1:0]        reach_b_q, reach_b_d;
   logic [N-1:0][N-1:0]        reach_w_q, reach_w_d;
   // Source maps with a zero border so edge cells see nothing off-board.
   logic [N+1:0][N+1:0]        src_b, src_w;

   logic [PW-1:0]              nb_stone, nw_stone, nb_terr, nw_terr;
   logic [CW-1:0]              bcount_d, wcount_d;
   logic signed [CW+1:0]       margin_d;
   logic [1:0]                 winner_d;

   logic [CW-1:0]              bcount_q, wcount_q;
   logic signed [CW+1:0]       margin_q;
   logic [1:0]                 winner_q;

   // One propagation pass: empty cells pick up reach from any 4-neighbour.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      src_b     = '0;
      src_w     = '0;
      reach_b_d = reach_b_q;
      reach_w_d = reach_w_q;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            src_b[r+1][c+1] = (board_q[r][c] == 2'b01) | reach_b_q[r][c];
            src_w[r+1][c+1] = (board_q[r][c] == 2'b10) | reach_w_q[r][c];
         end
      end
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            // Codes 00 and 11 are both empty.
            if (board_q[r][c][1] == board_q[r][c][0]) begin
               reach_b_d[r][c] = reach_b_q[r][c] | src_b[r][c+1] | src_b[r+2][c+1]
                               | src_b[r+1][c] | src_b[r+1][c+2];
               reach_w_d[r][c] = reach_w_q[r][c] | src_w[r][c+1] | src_w[r+2][c+1]
                               | src_w[r+1][c] | src_w[r+1][c+2];
            end
         end
      end
   end

   assign changed   = (reach_b_d != reach_b_q) || (reach_w_d != reach_w_q);
   assign last_pass = (pass_q == PW'(CELLS - 1));

   // Stone and territory counts, scores, margin and winner from the current maps.
   always_comb begin
      nb_stone = '0;
      nw_stone = '0;
      nb_terr  = '0;
      nw_terr  = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (board_q[r][c] == 2'b01) nb_stone = nb_stone + PW'(1);
            if (board_q[r][c] == 2'b10) nw_stone = nw_stone + PW'(1);
            if (board_q[r][c][1] == board_q[r][c][0]) begin
               if (reach_b_q[r][c] && !reach_w_q[r][c]) nb_terr = nb_terr + PW'(1);
               if (reach_w_q[r][c] && !reach_b_q[r][c]) nw_terr = nw_terr + PW'(1);
            end
         end
      end
      if (mode_q) begin
         bcount_d = CW'(nb_terr) + CW'(bcapt_q);
         wcount_d = CW'(nw_terr) + CW'(wcapt_q);
      end else begin
         bcount_d = CW'(nb_stone) + CW'(nb_terr);
         wcount_d = CW'(nw_stone) + CW'(nw_terr);
      end
      margin_d = $signed({1'b0, bcount_d, 1'b0}) - $signed({1'b0, wcount_d, 1'b0})
               - $signed((CW + 2)'(komi_q));
      if (margin_d > 0)      winner_d = 2'b01;
      else if (margin_d < 0) winner_d = 2'b10;
      else                   winner_d = 2'b11;
   end

   // Next-state logic and the one-deep pending request flag.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE:        if (update_pulse || pending_q) state_d = SNAPSHOT;
         SNAPSHOT:    state_d = PROPAGATE;
         PROPAGATE:   if (!changed || last_pass) state_d = TALLY;
         TALLY:       state_d = PULSE_READY;
         PULSE_READY: state_d = (pending_q || update_pulse) ? SNAPSHOT : IDLE;
         default:     state_d = IDLE;
      endcase
      if (state_q != IDLE && update_pulse) pending_d = 1'b1;
      if (state_d == SNAPSHOT)             pending_d = 1'b0;
   end

   // Control state, reach maps, pass counter and registered results.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q   <= IDLE;
         pending_q <= 1'b0;
         pass_q    <= '0;
         reach_b_q <= '0;
         reach_w_q <= '0;
         bcount_q  <= '0;
         wcount_q  <= '0;
         margin_q  <= '0;
         winner_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         case (state_q)
            SNAPSHOT: begin
               reach_b_q <= '0;
               reach_w_q <= '0;
               pass_q    <= '0;
            end
            PROPAGATE: begin
               reach_b_q <= reach_b_d;
               reach_w_q <= reach_w_d;
               pass_q    <= pass_q + PW'(1);
            end
            TALLY: begin
               bcount_q <= bcount_d;
               wcount_q <= wcount_d;
               margin_q <= margin_d;
               winner_q <= winner_d;
            end
            default: ;
         endcase
      end
   end

   // Snapshot of the request inputs, frozen for the whole computation.
   always_ff @(posedge clk_in) begin
      // NOTE: the snapshot is always loaded before it is read, so it carries no reset.
      if (state_q == SNAPSHOT) begin
         board_q <= board_state;
         mode_q  <= mode_in;
         bcapt_q <= bcapt_in;
         wcapt_q <= wcapt_in;
         komi_q  <= komi_in;
      end
   end

   assign bcount_out = bcount_q;
   assign wcount_out = wcount_q;
   assign margin_out = margin_q;
   assign winner_out = winner_q;
   assign busy_out   = (state_q != IDLE);
   assign terr_ready = (state_q == PULSE_READY);

endmodule

// File: tb/tb_territory_scorer.sv
// Directed self-checking bench for territory_scorer: expected results are
// queued when a request is issued and compared when terr_ready pulses.
module tb_territory_scorer;

   localparam int N  = 9;
   localparam int CW = 10;

   logic                      clk_in = 1'b0;
   logic                      rst_in;
   logic [N-1:0][N-1:0][1:0]  board_state;
   logic                      update_pulse;
   logic                      mode_in;
   logic [7:0]                bcapt_in, wcapt_in, komi_in;
   logic [CW-1:0]             bcount_out, wcount_out;
   logic signed [CW+1:0]      margin_out;
   logic [1:0]                winner_out;
   logic                      busy_out, terr_ready;

   territory_scorer #(.N(N), .CW(CW)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .board_state  (board_state),
      .update_pulse (update_pulse),
      .mode_in      (mode_in),
      .bcapt_in     (bcapt_in),
      .wcapt_in     (wcapt_in),
      .komi_in      (komi_in),
      .bcount_out   (bcount_out),
      .wcount_out   (wcount_out),
      .margin_out   (margin_out),
      .winner_out   (winner_out),
      .busy_out     (busy_out),
      .terr_ready   (terr_ready)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int b;
      int w;
      int m;
      int win;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   edges      = 0;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
      edges++;
   endtask

   task automatic push_exp(input int b, input int w, input int komi);
      exp_t e;
      e.b   = b;
      e.w   = w;
      e.m   = 2 * (b - w) - komi;
      e.win = (e.m > 0) ? 1 : (e.m < 0) ? 2 : 3;
      sb.push_back(e);
   endtask

   task automatic clear_board();
      board_state = '0;
   endtask

   task automatic columns_board();
      board_state = '0;
      for (int r = 0; r < N; r++) begin
         board_state[r][3] = 2'b01;
         board_state[r][5] = 2'b10;
      end
   endtask

   // Drive a request at a negedge; returns at the negedge after the sampling edge.
   task automatic start(input logic mode, input int bc, input int wc, input int komi);
      @(negedge clk_in);
      mode_in      = mode;
      bcapt_in     = 8'(bc);
      wcapt_in     = 8'(wc);
      komi_in      = 8'(komi);
      update_pulse = 1'b1;
      edges        = 0;
      tick();
      update_pulse = 1'b0;
   endtask

   // Wait (bounded) for terr_ready, then pop the scoreboard and compare.
   task automatic wait_ready(input string tag, input int exp_lat);
      exp_t e;
      do tick(); while (!terr_ready && edges < 400);
      check({tag, "_ready_seen"}, int'(terr_ready), 1);
      if (terr_ready) begin
         if (exp_lat > 0) check({tag, "_latency"}, edges + 1, exp_lat);
         check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_bcount"}, int'(bcount_out), e.b);
            check({tag, "_wcount"}, int'(wcount_out), e.w);
            check({tag, "_margin"}, int'(margin_out), e.m);
            check({tag, "_winner"}, int'(winner_out), e.win);
         end
      end
   endtask

   initial begin
      int n_ready;
      rst_in       = 1'b1;
      update_pulse = 1'b0;
      mode_in      = 1'b0;
      bcapt_in     = '0;
      wcapt_in     = '0;
      komi_in      = '0;
      clear_board();
      tick();
      tick();
      rst_in = 1'b0;

      check("rst_bcount", int'(bcount_out), 0);
      check("rst_wcount", int'(wcount_out), 0);
      check("rst_margin", int'(margin_out), 0);
      check("rst_winner", int'(winner_out), 0);
      check("rst_busy",   int'(busy_out),   0);
      check("rst_ready",  int'(terr_ready), 0);

      // Empty board, area, komi 13: one stable pass.
      clear_board();
      push_exp(0, 0, 13);
      start(1'b0, 0, 0, 13);
      check("empty_busy", int'(busy_out), 1);
      wait_ready("empty", 5);
      tick();
      check("empty_idle_busy", int'(busy_out), 0);

      // Single black stone in the centre: 8 growing passes plus a stable one.
      clear_board();
      board_state[4][4] = 2'b01;
      push_exp(81, 0, 0);
      start(1'b0, 0, 0, 0);
      wait_ready("stone", 13);

      // Split board, territory mode, black has two prisoners.
      columns_board();
      push_exp(29, 27, 0);
      start(1'b1, 2, 0, 0);
      wait_ready("terr", 8);

      // Same board, area mode, komi 1 then komi 0.
      push_exp(36, 36, 1);
      start(1'b0, 9, 9, 1);
      wait_ready("area_k1", 8);
      push_exp(36, 36, 0);
      start(1'b0, 0, 0, 0);
      tick();
      check("hold_margin", int'(margin_out), -1);
      check("hold_winner", int'(winner_out), 2);
      wait_ready("area_k0", 8);

      // Request during PROPAGATE plus an absorbed third one; board changes after SNAPSHOT.
      clear_board();
      board_state[4][4] = 2'b01;
      push_exp(81, 0, 0);
      start(1'b0, 0, 0, 0);
      tick();
      columns_board();
      mode_in  = 1'b1;
      bcapt_in = 8'd2;
      komi_in  = 8'd3;
      push_exp(29, 27, 3);
      tick();
      tick();
      update_pulse = 1'b1;
      tick();
      update_pulse = 1'b0;
      tick();
      update_pulse = 1'b1;
      tick();
      update_pulse = 1'b0;
      wait_ready("pend_first", 13);
      edges = 0;
      wait_ready("pend_second", 0);
      n_ready = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (terr_ready) n_ready++;
      end
      check("pend_no_third", n_ready, 0);

      // Reset for one cycle mid-PROPAGATE aborts the computation.
      clear_board();
      board_state[4][4] = 2'b01;
      start(1'b0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check("abort_bcount", int'(bcount_out), 0);
      check("abort_wcount", int'(wcount_out), 0);
      check("abort_margin", int'(margin_out), 0);
      check("abort_winner", int'(winner_out), 0);
      check("abort_busy",   int'(busy_out),   0);
      n_ready = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (terr_ready) n_ready++;
      end
      check("abort_no_ready", n_ready, 0);

      // A fresh request after the abort completes normally.
      columns_board();
      push_exp(29, 27, 0);
      start(1'b1, 2, 0, 0);
      wait_ready("after_abort", 8);
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/territory_scorer.md
TERRITORY_SCORER -- requirements
Module: territory_scorer

Interface
REQ-001 Parameter N, default 9: board edge length; legal values 9, 13, 19.
REQ-002 Parameter CW, default 10: score width; CW >= clog2(N*N+256).
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous and active-high.
REQ-005 board_state  input  2 x [N-1:0][N-1:0]  cell code: 00 empty, 01 black, 10 white, 11 treated as empty.
REQ-006 update_pulse  input  1  one-cycle request to score the current board_state.
REQ-007 mode_in  input  1  0 = area scoring, 1 = territory scoring; sampled with the board.
REQ-008 bcapt_in, wcapt_in  input  8 each  prisoners taken by black and by white; sampled with the board.
REQ-009 komi_in  input  8  komi in half-points, unsigned; sampled with the board.
REQ-010 bcount_out, wcount_out  output  CW each  final black and white scores in whole points.
REQ-011 margin_out  output  CW+2 signed  2*(bcount-wcount) - komi, in half-points.
REQ-012 winner_out  output  2  01 black, 10 white, 11 tie.
REQ-013 busy_out  output  1  high in every state except IDLE.
REQ-014 terr_ready  output  1  one-cycle pulse: outputs are valid and stable.

Function
REQ-015 FSM states: IDLE, SNAPSHOT, PROPAGATE, TALLY, PULSE_READY; one-hot encoding.
REQ-016 In IDLE, an asserted update_pulse moves the FSM to SNAPSHOT on the next edge.
REQ-017 SNAPSHOT (1 cycle): register board_state, mode_in, bcapt_in, wcapt_in, komi_in; clear reach_b and reach_w (N*N bits each); go to PROPAGATE.
REQ-018 PROPAGATE, one pass per cycle: an empty cell sets reach_b when any 4-neighbour is black or has reach_b; reach_w is computed the same way for white; set bits never clear.
REQ-019 Board edges have no wrap-around; off-board neighbours contribute nothing.
REQ-020 PROPAGATE exits to TALLY after the first pass in which neither reach map changes, or after N*N passes, whichever comes first.
REQ-021 Black territory = empty cells with reach_b and not reach_w; white territory is the mirror; cells with both bits set (dame) score for nobody.
REQ-022 TALLY (1 cycle), area mode: score = stones of that colour + its territory, prisoners ignored.
REQ-023 TALLY, territory mode: black score = black territory + bcapt; white score = white territory + wcapt.
REQ-024 TALLY registers margin_out and winner_out from the new scores and the latched komi.
REQ-025 winner_out: margin > 0 gives 01, margin < 0 gives 10, margin = 0 gives 11.
REQ-026 All outputs except terr_ready, busy_out and the state register update only on the edge that leaves TALLY.
REQ-027 PULSE_READY (1 cycle): terr_ready = 1; the next state is IDLE, or SNAPSHOT if a request is pending.
REQ-028 update_pulse in any non-IDLE state sets a one-deep pending flag; further pulses are absorbed.
REQ-029 The pending flag clears on entry to SNAPSHOT.
REQ-030 Latency from update_pulse to terr_ready = P + 4 cycles, where P is the number of PROPAGATE cycles (P <= N*N).
REQ-031 board_state may change after SNAPSHOT without affecting the result in flight.

Reset
REQ-032 rst_in clears all outputs to 0, both reach maps, the pending flag and the pass counter, and sets the state to IDLE.
REQ-033 rst_in asserted in any state, including mid-PROPAGATE, aborts the computation; no terr_ready follows.

Verification
REQ-034 N=9, empty board, area mode, komi 13 -> bcount 0, wcount 0, margin -13, winner 10; P = 1.
REQ-035 Single black stone at (4,4), area mode, komi 0 -> bcount 81, wcount 0, winner 01; P = 9 (8 changing passes plus 1 stable pass).
REQ-036 Black column 3, white column 5, column 4 empty, territory mode, bcapt 2, wcapt 0, komi 0 -> bcount 29, wcount 27, margin 4.
REQ-037 Same board in area mode -> bcount 36, wcount 36, komi 1 -> margin -1, winner 10; komi 0 -> winner 11.
REQ-038 Second update_pulse during PROPAGATE plus a third pulse -> exactly two terr_ready pulses, the second reflecting the board at the second SNAPSHOT.
REQ-039 rst_in for one cycle mid-PROPAGATE -> all outputs 0, no terr_ready; a new update_pulse then completes normally.
